// File: rtl/multiplier_1_if.sv
// Operand/result bundle for the approximate 4x4 multiplier.
// err_mag exists only when MULT_ERR_METRIC_EN is defined.
interface multiplier_1_if;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] result;
  logic       out_valid;
`ifdef MULT_ERR_METRIC_EN
  logic [7:0] err_mag;

  modport master (output in_valid, A, B, input result, out_valid, err_mag);
  modport slave  (input in_valid, A, B, output result, out_valid, err_mag);
`else
  modport master (output in_valid, A, B, input result, out_valid);
  modport slave  (input in_valid, A, B, output result, out_valid);
`endif
endinterface

// File: rtl/multiplier_1.sv
// Unsigned 4x4 approximate multiplier, one registered stage; low columns OR-compressed.
// Optional MULT_ERR_METRIC_EN adds a registered err_mag = exact - approximate.
module multiplier_1 #(
  parameter int APPROX_COLS = 3
) (
  input  logic           clk,
  input  logic           rst,
  multiplier_1_if.slave  bus
);

  logic [7:0] or_bits;
  logic [7:0] exact_sum;
  logic [7:0] approx;

  // Approximate columns only OR their partial products, so they never carry;
  // everything at or above APPROX_COLS is accumulated exactly.
  always_comb begin
    or_bits   = '0;
    exact_sum = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i + j < APPROX_COLS)
          or_bits[i + j] = or_bits[i + j] | (bus.A[i] & bus.B[j]);
        else
          exact_sum = exact_sum + ({7'd0, bus.A[i] & bus.B[j]} << (i + j));
      end
    end
    approx = exact_sum | or_bits;
  end

`ifdef MULT_ERR_METRIC_EN
  logic [7:0] exact_prod;

  assign exact_prod = {4'd0, bus.A} * {4'd0, bus.B};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result    <= '0;
      bus.out_valid <= 1'b0;
`ifdef MULT_ERR_METRIC_EN
      bus.err_mag   <= '0;
`endif
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.result  <= approx;
`ifdef MULT_ERR_METRIC_EN
        bus.err_mag <= exact_prod - approx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_multiplier_1.sv
// Directed bench for multiplier_1: default APPROX_COLS=3 instance and an exact (0) instance.
module tb_multiplier_1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  multiplier_1_if bus ();
  multiplier_1_if bus_x ();

  multiplier_1 dut (.clk(clk), .rst(rst), .bus(bus));
  multiplier_1 #(.APPROX_COLS(0)) dut_x (.clk(clk), .rst(rst), .bus(bus_x));

  always #5 clk = ~clk;

  // Independent formulation: exact product, then swap each approximate
  // column's full weight (count * 2^k) for its OR weight (2^k if any set).
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input int cols);
    int cnt [7];
    int val;
    for (int k = 0; k < 7; k++) cnt[k] = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (a[i] && b[j]) cnt[i + j]++;
    val = int'(a) * int'(b);
    for (int k = 0; k < cols; k++)
      val = val - cnt[k] * (1 << k) + ((cnt[k] > 0) ? (1 << k) : 0);
    return 8'(val);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    bus.in_valid   = v;
    bus.A          = a;
    bus.B          = b;
    bus_x.in_valid = v;
    bus_x.A        = a;
    bus_x.B        = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 4'd15, 4'd15);

    // Reset overrides in_valid
    rst = 1'b1;
    tick();
    check("rst_result", bus.result, 8'd0);
    check("rst_valid", {7'd0, bus.out_valid}, 8'd0);
    check("rst_result_x", bus_x.result, 8'd0);
`ifdef MULT_ERR_METRIC_EN
    check("rst_err", bus.err_mag, 8'd0);
`endif

    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    tick();
    check("idle_valid", {7'd0, bus.out_valid}, 8'd0);

    // First accepted op appears one cycle later
    drive(1'b1, 4'd3, 4'd3);
    tick();
    check("3x3_valid", {7'd0, bus.out_valid}, 8'd1);
    check("3x3", bus.result, 8'd7);
    check("3x3_exact", bus_x.result, 8'd9);
`ifdef MULT_ERR_METRIC_EN
    check("3x3_err", bus.err_mag, 8'd2);
`endif

    drive(1'b1, 4'd15, 4'd15);
    tick();
    check("15x15", bus.result, 8'd215);
    check("15x15_exact", bus_x.result, 8'd225);
`ifdef MULT_ERR_METRIC_EN
    check("15x15_err", bus.err_mag, 8'd10);
`endif

    // Error-free cases
    drive(1'b1, 4'd4, 4'd5);
    tick();
    check("4x5", bus.result, 8'd20);
    drive(1'b1, 4'd1, 4'd13);
    tick();
    check("1x13", bus.result, 8'd13);
    drive(1'b1, 4'd0, 4'd9);
    tick();
    check("0x9", bus.result, 8'd0);
    drive(1'b1, 4'd8, 4'd8);
    tick();
    check("8x8", bus.result, 8'd64);
`ifdef MULT_ERR_METRIC_EN
    check("8x8_err", bus.err_mag, 8'd0);
`endif

    // Hold: 6x7 -> 38 (exact 42), then three idle cycles with changing operands
    drive(1'b1, 4'd6, 4'd7);
    tick();
    check("6x7", bus.result, 8'd38);
    check("6x7_exact", bus_x.result, 8'd42);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 4'd15, 4'(c + 1));
      tick();
      check("hold_result", bus.result, 8'd38);
      check("hold_valid", {7'd0, bus.out_valid}, 8'd0);
`ifdef MULT_ERR_METRIC_EN
      check("hold_err", bus.err_mag, 8'd4);
`endif
    end

    // Mid-stream reset discards the in-flight op
    drive(1'b1, 4'd15, 4'd15);
    rst = 1'b1;
    tick();
    check("mid_rst_result", bus.result, 8'd0);
    check("mid_rst_valid", {7'd0, bus.out_valid}, 8'd0);
    rst = 1'b0;

    // Exhaustive sweep, one pair per cycle
    for (int n = 0; n < 256; n++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] exact;
      a = 4'(n >> 4);
      b = 4'(n);
      exact = 8'(int'(a) * int'(b));
      drive(1'b1, a, b);
      tick();
      check("sweep_valid", {7'd0, bus.out_valid}, 8'd1);
      check("sweep_model", bus.result, model(a, b, 3));
      check("sweep_le", {7'd0, bus.result <= exact}, 8'd1);
      check("sweep_exact", bus_x.result, exact);
`ifdef MULT_ERR_METRIC_EN
      check("sweep_err", bus.err_mag, exact - model(a, b, 3));
`endif
    end

    drive(1'b0, 4'd0, 4'd0);
    tick();
    check("end_valid", {7'd0, bus.out_valid}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
